// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects
// and the hard-wired zero register index.
package pipe_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the datapath and pipe_hazard_ctrl. The perf counter
// outputs exist only when HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_br_taken;
    logic [4:0]  mem_rd;
    logic        mem_reg_wr;
    logic        mem_req;
    logic        dmem_ready;
    logic [4:0]  wb_rd;
    logic        wb_reg_wr;
    logic        err_clr;
    logic        stall_if;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        stall_id_ex;
    logic        stall_ex_mem;
    logic        flush_mem_wb;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        mem_err;
    logic [1:0]  fsm_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    // Datapath side: drives decoded pipeline fields, consumes control.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_mem_read, ex_br_taken, mem_rd, mem_reg_wr, mem_req, dmem_ready,
               wb_rd, wb_reg_wr, err_clr,
        input  stall_if, flush_if_id, flush_id_ex, stall_id_ex, stall_ex_mem,
               flush_mem_wb, fwd_a, fwd_b, mem_err, fsm_state
`ifdef HAZARD_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_mem_read, ex_br_taken, mem_rd, mem_reg_wr, mem_req, dmem_ready,
               wb_rd, wb_reg_wr, err_clr,
        output stall_if, flush_if_id, flush_id_ex, stall_id_ex, stall_ex_mem,
               flush_mem_wb, fwd_a, fwd_b, mem_err, fsm_state
`ifdef HAZARD_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_fwd_unit.sv
// Forwarding select for one EX operand; the younger EX/MEM result wins over MEM/WB.
module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_wr,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_wr,
    output fwd_sel_t   sel
);
    always_comb begin
        sel = FWD_RF;
        if (mem_reg_wr && mem_rd != REG_X0 && mem_rd == rs) begin
            sel = FWD_MEM;
        end else if (wb_reg_wr && wb_rd != REG_X0 && wb_rd == rs) begin
            sel = FWD_WB;
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: stall/flush priority, operand forwarding and a dmem wait FSM
// with timeout watchdog. Define HAZARD_PERF_EN to add stall/flush perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    hz_state_t       state, state_next;
    logic [TO_W-1:0] cnt, cnt_next;
    logic            err_q;
    logic            err_set;
    logic            freeze;
    logic            in_err;
    logic            load_use;
    fwd_sel_t        sel_a, sel_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (hz.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Unused encoding 3 falls into default and behaves exactly like RUN.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_set    = 1'b0;
        freeze     = 1'b0;
        in_err     = 1'b0;
        case (state)
            MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    freeze = 1'b1;
                    if (cnt == TO_W'(MEM_TIMEOUT)) begin
                        state_next = MEM_ERR;
                        cnt_next   = '0;
                        err_set    = 1'b1;
                    end else begin
                        cnt_next = cnt + TO_W'(1);
                    end
                end
            end
            MEM_ERR: begin
                in_err     = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
                if (hz.mem_req && !hz.dmem_ready) begin
                    freeze     = 1'b1;
                    state_next = MEM_WAIT;
                    cnt_next   = TO_W'(1);
                end
            end
        endcase
    end

    assign load_use = hz.ex_mem_read && hz.ex_rd != REG_X0 &&
                      ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                       (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));

    // Priority: memory freeze, then taken branch, then load-use bubble.
    always_comb begin
        hz.stall_if     = 1'b0;
        hz.flush_if_id  = 1'b0;
        hz.flush_id_ex  = 1'b0;
        hz.stall_id_ex  = 1'b0;
        hz.stall_ex_mem = 1'b0;
        hz.flush_mem_wb = in_err;
        if (freeze) begin
            hz.stall_if     = 1'b1;
            hz.stall_id_ex  = 1'b1;
            hz.stall_ex_mem = 1'b1;
            hz.flush_mem_wb = 1'b1;
        end else if (hz.ex_br_taken) begin
            hz.flush_if_id = 1'b1;
            hz.flush_id_ex = 1'b1;
        end else if (load_use) begin
            hz.stall_if    = 1'b1;
            hz.flush_id_ex = 1'b1;
        end
    end

    pipe_fwd_unit u_fwd_a (
        .rs         (hz.ex_rs1),
        .mem_rd     (hz.mem_rd),
        .mem_reg_wr (hz.mem_reg_wr),
        .wb_rd      (hz.wb_rd),
        .wb_reg_wr  (hz.wb_reg_wr),
        .sel        (sel_a)
    );

    pipe_fwd_unit u_fwd_b (
        .rs         (hz.ex_rs2),
        .mem_rd     (hz.mem_rd),
        .mem_reg_wr (hz.mem_reg_wr),
        .wb_rd      (hz.wb_rd),
        .wb_reg_wr  (hz.wb_reg_wr),
        .sel        (sel_b)
    );

    assign hz.fwd_a     = sel_a;
    assign hz.fwd_b     = sel_b;
    assign hz.mem_err   = err_q;
    assign hz.fsm_state = state;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.stall_if && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((hz.flush_if_id || hz.flush_id_ex) && flush_cnt != 32'hFFFF_FFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cnt = stall_cnt;
    assign hz.perf_flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): directed plan steps followed by
// random traffic, all compared against a behavioural model of the controller rules.
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int S_RUN = 0, S_WAIT = 1, S_ERR = 2;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: abstract phase, cycles spent waiting, sticky error.
    int      m_phase;
    int      m_waited;
    bit      m_err;
    longint  m_stalls;
    longint  m_flushes;
    bit      e_stall_if, e_flush_if_id, e_flush_id_ex, e_stall_id_ex, e_stall_ex_mem, e_flush_mem_wb;
    int      e_fwd_a, e_fwd_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd_model(input logic [4:0] rs);
        if (hz.mem_reg_wr && hz.mem_rd != 0 && hz.mem_rd == rs) return 1;
        if (hz.wb_reg_wr && hz.wb_rd != 0 && hz.wb_rd == rs) return 2;
        return 0;
    endfunction

    task automatic model_outputs();
        bit frozen, lu;
        frozen = !hz.dmem_ready && ((m_phase == S_RUN && hz.mem_req) || m_phase == S_WAIT);
        lu = hz.ex_mem_read && hz.ex_rd != 0 &&
             ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        e_stall_if     = frozen || (!hz.ex_br_taken && lu);
        e_stall_id_ex  = frozen;
        e_stall_ex_mem = frozen;
        e_flush_mem_wb = frozen || m_phase == S_ERR;
        e_flush_if_id  = !frozen && hz.ex_br_taken;
        e_flush_id_ex  = !frozen && (hz.ex_br_taken || lu);
        e_fwd_a        = fwd_model(hz.ex_rs1);
        e_fwd_b        = fwd_model(hz.ex_rs2);
    endtask

    task automatic model_clock();
        bit timed_out;
        timed_out = 1'b0;
        if (e_stall_if && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        if ((e_flush_if_id || e_flush_id_ex) && m_flushes < 64'hFFFF_FFFF) m_flushes++;
        if (m_phase == S_ERR) begin
            m_phase = S_RUN;
        end else if (m_phase == S_WAIT) begin
            if (hz.dmem_ready) begin
                m_phase = S_RUN; m_waited = 0;
            end else if (m_waited == TIMEOUT) begin
                m_phase = S_ERR; timed_out = 1'b1;
            end else begin
                m_waited++;
            end
        end else if (hz.mem_req && !hz.dmem_ready) begin
            m_phase = S_WAIT; m_waited = 1;
        end
        if (timed_out) m_err = 1'b1;
        else if (hz.err_clr) m_err = 1'b0;
    endtask

    task automatic model_reset();
        m_phase = S_RUN; m_waited = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic check_comb(input string tag);
        model_outputs();
        check({tag, ".stall_if"},     32'(hz.stall_if),     32'(e_stall_if));
        check({tag, ".flush_if_id"},  32'(hz.flush_if_id),  32'(e_flush_if_id));
        check({tag, ".flush_id_ex"},  32'(hz.flush_id_ex),  32'(e_flush_id_ex));
        check({tag, ".stall_id_ex"},  32'(hz.stall_id_ex),  32'(e_stall_id_ex));
        check({tag, ".stall_ex_mem"}, 32'(hz.stall_ex_mem), 32'(e_stall_ex_mem));
        check({tag, ".flush_mem_wb"}, 32'(hz.flush_mem_wb), 32'(e_flush_mem_wb));
        check({tag, ".fwd_a"},        32'(hz.fwd_a),        32'(e_fwd_a));
        check({tag, ".fwd_b"},        32'(hz.fwd_b),        32'(e_fwd_b));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".fsm_state"}, 32'(hz.fsm_state), 32'(m_phase));
        check({tag, ".mem_err"},   32'(hz.mem_err),   32'(m_err));
`ifdef HAZARD_PERF_EN
        check({tag, ".perf_stall"}, hz.perf_stall_cnt, 32'(m_stalls));
        check({tag, ".perf_flush"}, hz.perf_flush_cnt, 32'(m_flushes));
`endif
    endtask

    // Inputs are set by the caller just after a rising edge; check, clock, check.
    task automatic tick(input string tag);
        #1;
        check_comb(tag);
        @(posedge clk);
        model_clock();
        #1;
        check_regs(tag);
    endtask

    task automatic set_idle();
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_rs1 = 0; hz.ex_rs2 = 0; hz.ex_rd = 0; hz.ex_mem_read = 0; hz.ex_br_taken = 0;
        hz.mem_rd = 0; hz.mem_reg_wr = 0; hz.mem_req = 0; hz.dmem_ready = 0;
        hz.wb_rd = 0; hz.wb_reg_wr = 0; hz.err_clr = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        set_idle();
        model_reset();
        reset = 1'b0;
        #2;
        check_comb("reset");
        check_regs("reset");
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Load-use bubble, then gone once the load leaves EX
        hz.ex_mem_read = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_use_rs1 = 1;
        tick("loaduse");
        hz.ex_mem_read = 0;
        tick("loaduse_done");

        // Taken branch overrides load-use
        hz.ex_mem_read = 1; hz.ex_br_taken = 1;
        tick("branch");
        set_idle();

        // Three-cycle memory wait with a branch pending underneath
        hz.mem_req = 1; hz.dmem_ready = 0; hz.ex_br_taken = 1;
        for (int i = 0; i < 3; i++) tick("memwait");
        hz.dmem_ready = 1;
        tick("memrelease");
        set_idle();
        tick("idle");

        // Timeout: RUN -> MEM_WAIT (4 counts) -> MEM_ERR -> RUN
        hz.mem_req = 1;
        for (int i = 0; i < 6; i++) tick("timeout");
        hz.mem_req = 0;
        tick("err_sticky");
        tick("err_sticky");
        hz.err_clr = 1;
        tick("err_clr");
        hz.err_clr = 0;

        // Clear and timeout on the same edge: set wins
        hz.mem_req = 1;
        for (int i = 0; i < 5; i++) begin
            hz.err_clr = (i == 4);
            tick("clr_vs_set");
        end
        hz.err_clr = 0; hz.mem_req = 0;
        tick("after_clr_vs_set");

        // Forwarding priority
        hz.mem_rd = 3; hz.mem_reg_wr = 1; hz.wb_rd = 3; hz.wb_reg_wr = 1; hz.ex_rs1 = 3;
        tick("fwd_mem");
        hz.mem_reg_wr = 0;
        tick("fwd_wb");
        hz.mem_rd = 0; hz.mem_reg_wr = 1; hz.ex_rs2 = 0; hz.wb_rd = 0;
        tick("fwd_x0");
        set_idle();

        // Asynchronous reset while in MEM_WAIT
        hz.mem_req = 1;
        tick("pre_reset");
        tick("pre_reset");
        hz.mem_req = 0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_comb("async_reset");
        check_regs("async_reset");
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic over a small register space to provoke matches
        for (int i = 0; i < 400; i++) begin
            hz.id_rs1 = 5'($urandom_range(0, 3)); hz.id_rs2 = 5'($urandom_range(0, 3));
            hz.id_use_rs1 = 1'($urandom); hz.id_use_rs2 = 1'($urandom);
            hz.ex_rs1 = 5'($urandom_range(0, 3)); hz.ex_rs2 = 5'($urandom_range(0, 3));
            hz.ex_rd = 5'($urandom_range(0, 3));
            hz.ex_mem_read = 1'($urandom); hz.ex_br_taken = ($urandom_range(0, 3) == 0);
            hz.mem_rd = 5'($urandom_range(0, 3)); hz.mem_reg_wr = 1'($urandom);
            hz.wb_rd = 5'($urandom_range(0, 3)); hz.wb_reg_wr = 1'($urandom);
            hz.mem_req = ($urandom_range(0, 9) < 4);
            hz.dmem_ready = ($urandom_range(0, 9) < 3);
            hz.err_clr = ($urandom_range(0, 9) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Generates per-stage stall and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Selects EX-stage operand forwarding.
- Sequences multi-cycle data-memory accesses with a wait FSM and a timeout watchdog.
- Sits beside the datapath; consumes decoded register indices and control bits from each pipeline register.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before declaring a memory error (>=2)
TO_W, $clog2(MEM_TIMEOUT+1), width of the wait counter

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rs1  in  5  rs1 at ID/EX output
ex_rs2  in  5  rs2 at ID/EX output
ex_rd  in  5  rd at ID/EX output
ex_mem_read  in  1  EX instruction is a load
ex_br_taken  in  1  branch/jump resolved taken in EX
mem_rd  in  5  rd at EX/MEM output
mem_reg_wr  in  1  EX/MEM writes regfile
mem_req  in  1  EX/MEM holds a load/store (dmem request)
dmem_ready  in  1  data memory completes current request
wb_rd  in  5  rd at MEM/WB output
wb_reg_wr  in  1  MEM/WB writes regfile
err_clr  in  1  clears sticky mem_err
stall_if  out  1  hold PC and IF/ID
flush_if_id  out  1  bubble into IF/ID
flush_id_ex  out  1  bubble into ID/EX
stall_id_ex  out  1  hold ID/EX
stall_ex_mem  out  1  hold EX/MEM
flush_mem_wb  out  1  bubble into MEM/WB
fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  EX operand B source: same encoding
mem_err  out  1  sticky: dmem timeout occurred
fsm_state  out  2  current state (debug)

Behaviour:
- Reset (reset=0, async):
  - State RUN, counter 0, mem_err 0.
  - All outputs evaluate from RUN with cleared state.
- FSM states: RUN=0, MEM_WAIT=1, MEM_ERR=2. Encoding 3 is unreachable and decodes as RUN.
- RUN:
  - mem_req && !dmem_ready -> MEM_WAIT, counter <= 1.
  - mem_req && dmem_ready -> stay RUN (single-cycle access).
- MEM_WAIT:
  - dmem_ready -> RUN, counter <= 0.
  - else if counter == MEM_TIMEOUT -> MEM_ERR, mem_err <= 1.
  - else counter++. Counter never wraps.
- MEM_ERR:
  - Next cycle -> RUN (access abandoned; the instruction completes as a bubble).
  - mem_err stays 1 until err_clr=1. err_clr and a new timeout in the same cycle: set wins.
- Memory freeze (combinational). Condition: (RUN && mem_req && !dmem_ready) or MEM_WAIT && !dmem_ready.
  - Asserts stall_if, stall_id_ex, stall_ex_mem and flush_mem_wb.
  - Forces flush_if_id=0 and flush_id_ex=0.
  - Freeze has highest priority; branch and load-use are re-evaluated on the cycle the freeze releases.
- MEM_ERR cycle: flush_mem_wb=1, no stalls.
- Branch (no freeze): ex_br_taken=1 -> flush_if_id=1, flush_id_ex=1, stall_if=0. Overrides load-use.
- Load-use (no freeze, no branch):
  - Condition: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - Response: stall_if=1, flush_id_ex=1, for exactly one cycle per hazard.
- Forwarding (fwd_a/ex_rs1; fwd_b identical with ex_rs2):
  - 01 if mem_reg_wr && mem_rd!=0 && mem_rd==ex_rs1.
  - else 10 if wb_reg_wr && wb_rd!=0 && wb_rd==ex_rs1.
  - else 00.
  - EX/MEM has priority over MEM/WB. Forwarding is independent of stall/flush.
- All stall/flush/forward outputs are combinational. Only state, counter and mem_err are registered.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on each cycle with stall_if=1.
  - perf_flush_cnt increments on each cycle with flush_if_id=1 or flush_id_ex=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] hz_state_t {RUN, MEM_WAIT, MEM_ERR}.
  - typedef enum logic [1:0] fwd_sel_t {FWD_RF=0, FWD_MEM=1, FWD_WB=2}.
  - Localparam REG_X0 = 5'd0.
- One sub-module: pipe_fwd_unit, purely combinational forwarding compare for one operand, instantiated twice (A, B).

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> stall_if=1, flush_id_ex=1 for one cycle. Next cycle ex_mem_read=0 -> both 0.
2. Branch over load-use: same as 1 plus ex_br_taken=1 -> flush_if_id=1, flush_id_ex=1, stall_if=0.
3. Multi-cycle memory: mem_req=1, dmem_ready low 3 cycles then high.
   - State goes RUN->MEM_WAIT; stall_if, stall_id_ex, stall_ex_mem, flush_mem_wb are 1 for 3 cycles.
   - Ready cycle: all 0, state RUN. Concurrent ex_br_taken during the wait produces no flush until release.
4. Timeout: MEM_TIMEOUT=4, dmem_ready never rises.
   - MEM_ERR after counter reaches 4; mem_err=1 and stays 1.
   - err_clr=1 -> mem_err=0. Simultaneous err_clr and new timeout -> mem_err=1.
5. Forwarding: mem_rd=3/mem_reg_wr=1, wb_rd=3/wb_reg_wr=1, ex_rs1=3 -> fwd_a=01.
   - mem_reg_wr=0 -> fwd_a=10.
   - ex_rs2=0 with mem_rd=0 -> fwd_b=00.
6. Reset mid-wait: drive reset=0 asynchronously in MEM_WAIT -> state RUN, counter 0, mem_err 0, all stalls deasserted immediately (mem_req=0); perf counters 0 if HAZARD_PERF_EN is defined.
